// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, acknowledge handshake,
// frame-error and overrun reporting.
module uart_rx #(
    parameter int CLOCKS_PER_BAUD = 4
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic       rx_i,
    input  logic       ack_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_error_o,
    output logic       overrun_o
);
    localparam int CW = $clog2(CLOCKS_PER_BAUD) + 1;
    localparam logic [CW-1:0] FULL = CW'(CLOCKS_PER_BAUD - 1);
    localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_BAUD / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        r_state;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_bit;
    logic [7:0]    r_shift;
    logic          w_rxs;
    logic          w_tick;

    assign w_rxs  = r_sync[1];
    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state       <= IDLE;
            r_sync        <= 2'b11;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            data_o        <= 8'h00;
            valid_o       <= 1'b0;
            frame_error_o <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            r_sync        <= {r_sync[0], rx_i};
            frame_error_o <= 1'b0;
            overrun_o     <= 1'b0;
            // a completing byte below overrides this clear when both coincide
            if (ack_i && valid_o)
                valid_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state <= START;
                        r_cnt   <= HALF;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state <= w_rxs ? IDLE : DATA;
                        r_cnt   <= FULL;
                        r_bit   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_rxs, r_shift[7:1]};
                        r_cnt   <= FULL;
                        if (r_bit == CW'(7))
                            r_state <= STOP;
                        else
                            r_bit <= r_bit + CW'(1);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (!w_rxs) begin
                            frame_error_o <= 1'b1;
                            r_state       <= BREAK;
                        end else if (valid_o && !ack_i) begin
                            overrun_o <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            data_o  <= r_shift;
                            valid_o <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                BREAK: begin
                    if (w_rxs)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level model.
module tb_uart_rx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic       rx_a = 1'b1, ack_a = 1'b0, rx_b = 1'b1, ack_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic       valid_a, fe_a, ov_a, valid_b, fe_b, ov_b;

    int total = 0, bad = 0;
    int fe_cyc = 0, ov_cyc = 0, rises = 0;
    logic prev_v = 1'b0;

    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    int         m_fe = 0, m_ov = 0;

    uart_rx #(.CLOCKS_PER_BAUD(4)) u_a (
        .clock_i(clk), .reset_n_i(rst_n), .rx_i(rx_a), .ack_i(ack_a),
        .data_o(data_a), .valid_o(valid_a), .frame_error_o(fe_a), .overrun_o(ov_a)
    );

    uart_rx #(.CLOCKS_PER_BAUD(16)) u_b (
        .clock_i(clk), .reset_n_i(rst_n), .rx_i(rx_b), .ack_i(ack_b),
        .data_o(data_b), .valid_o(valid_b), .frame_error_o(fe_b), .overrun_o(ov_b)
    );

    always @(negedge clk) begin
        fe_cyc = fe_cyc + (fe_a ? 1 : 0);
        ov_cyc = ov_cyc + (ov_a ? 1 : 0);
        if (valid_a && !prev_v) rises = rises + 1;
        prev_v = valid_a;
    end

    // Frame-level reference: what a receiver must report for a whole frame.
    function automatic void m_frame(input logic [7:0] b, input bit stop, input bit ack);
        if (!stop) m_fe++;
        else if (m_valid && !ack) m_ov++;
        else begin
            m_data  = b;
            m_valid = 1'b1;
        end
    endfunction

    task automatic send(input bit which, input logic [7:0] b, input bit stop);
        logic [9:0] f;
        int cpb;
        f   = {stop, b, 1'b0};
        cpb = which ? 16 : 4;
        for (int i = 0; i < 10; i++) begin
            if (which) rx_b = f[i];
            else rx_a = f[i];
            repeat (cpb) @(negedge clk);
        end
    endtask

    task automatic ack_pulse();
        ack_a = 1'b1;
        @(negedge clk);
        ack_a   = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic test_reset();
        rx_a = 1'b1;
        rx_b = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total += 4;
        if (data_a !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_a); end
        if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
        if (fe_a !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b exp=0", fe_a); end
        if (ov_a !== 1'b0) begin bad++; $display("FAIL reset_ov got=%b exp=0", ov_a); end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (valid_a !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", valid_a); end
    endtask

    task automatic test_loopback();
        int r0;
        r0 = rises;
        send(0, 8'hA5, 1);
        m_frame(8'hA5, 1, 0);
        repeat (8) @(negedge clk);
        total += 3;
        if (rises - r0 !== 1) begin bad++; $display("FAIL loop_rises got=%0d exp=1", rises - r0); end
        if (data_a !== m_data) begin bad++; $display("FAIL loop_data got=%h exp=%h", data_a, m_data); end
        if (valid_a !== m_valid) begin bad++; $display("FAIL loop_valid got=%b exp=%b", valid_a, m_valid); end
        ack_pulse();
        total++;
        if (valid_a !== 1'b0) begin bad++; $display("FAIL loop_ack got=%b exp=0", valid_a); end
    endtask

    task automatic test_false_start();
        int r0, f0, o0;
        r0 = rises; f0 = fe_cyc; o0 = ov_cyc;
        rx_a = 1'b0;
        @(negedge clk);
        rx_a = 1'b1;
        repeat (12) @(negedge clk);
        total += 3;
        if (rises !== r0) begin bad++; $display("FAIL glitch_valid got=%0d exp=%0d", rises, r0); end
        if (fe_cyc !== f0) begin bad++; $display("FAIL glitch_fe got=%0d exp=%0d", fe_cyc, f0); end
        if (ov_cyc !== o0) begin bad++; $display("FAIL glitch_ov got=%0d exp=%0d", ov_cyc, o0); end
        send(0, 8'h3C, 1);
        m_frame(8'h3C, 1, 0);
        repeat (8) @(negedge clk);
        total += 3;
        if (data_a !== m_data) begin bad++; $display("FAIL glitch_data got=%h exp=%h", data_a, m_data); end
        if (valid_a !== m_valid) begin bad++; $display("FAIL glitch_rx_valid got=%b exp=%b", valid_a, m_valid); end
        if (rises - r0 !== 1) begin bad++; $display("FAIL glitch_rises got=%0d exp=1", rises - r0); end
        ack_pulse();
    endtask

    task automatic test_break();
        send(0, 8'hFF, 0);
        m_frame(8'hFF, 0, 0);
        repeat (50) @(negedge clk);
        total += 4;
        if (fe_cyc !== m_fe) begin bad++; $display("FAIL break_fe got=%0d exp=%0d", fe_cyc, m_fe); end
        if (valid_a !== 1'b0) begin bad++; $display("FAIL break_valid got=%b exp=0", valid_a); end
        if (data_a !== m_data) begin bad++; $display("FAIL break_data got=%h exp=%h", data_a, m_data); end
        if (ov_cyc !== m_ov) begin bad++; $display("FAIL break_ov got=%0d exp=%0d", ov_cyc, m_ov); end
        rx_a = 1'b1;
        repeat (8) @(negedge clk);
        send(0, 8'h01, 1);
        m_frame(8'h01, 1, 0);
        repeat (8) @(negedge clk);
        total += 3;
        if (data_a !== m_data) begin bad++; $display("FAIL break_rx_data got=%h exp=%h", data_a, m_data); end
        if (valid_a !== m_valid) begin bad++; $display("FAIL break_rx_valid got=%b exp=%b", valid_a, m_valid); end
        if (fe_cyc !== m_fe) begin bad++; $display("FAIL break_fe_after got=%0d exp=%0d", fe_cyc, m_fe); end
        ack_pulse();
    endtask

    task automatic test_overrun();
        send(0, 8'h11, 1);
        send(0, 8'h22, 1);
        m_frame(8'h11, 1, 0);
        m_frame(8'h22, 1, 0);
        repeat (8) @(negedge clk);
        total += 3;
        if (ov_cyc !== m_ov) begin bad++; $display("FAIL ovr_pulse got=%0d exp=%0d", ov_cyc, m_ov); end
        if (data_a !== m_data) begin bad++; $display("FAIL ovr_data got=%h exp=%h", data_a, m_data); end
        if (valid_a !== m_valid) begin bad++; $display("FAIL ovr_valid got=%b exp=%b", valid_a, m_valid); end
        ack_pulse();
        // the second stop bit is sampled on the 81st rising edge after the first start edge
        fork
            begin
                send(0, 8'h11, 1);
                send(0, 8'h22, 1);
            end
            begin
                repeat (80) @(negedge clk);
                ack_a = 1'b1;
                @(negedge clk);
                ack_a = 1'b0;
            end
        join
        m_frame(8'h11, 1, 0);
        m_frame(8'h22, 1, 1);
        repeat (8) @(negedge clk);
        total += 3;
        if (ov_cyc !== m_ov) begin bad++; $display("FAIL coinc_ov got=%0d exp=%0d", ov_cyc, m_ov); end
        if (data_a !== m_data) begin bad++; $display("FAIL coinc_data got=%h exp=%h", data_a, m_data); end
        if (valid_a !== m_valid) begin bad++; $display("FAIL coinc_valid got=%b exp=%b", valid_a, m_valid); end
        ack_pulse();
    endtask

    task automatic test_reset_midframe();
        send(0, 8'hC3, 1);
        m_frame(8'hC3, 1, 0);
        repeat (8) @(negedge clk);
        fork
            send(0, 8'h96, 1);
            begin
                repeat (22) @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                total += 4;
                if (data_a !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h exp=00", data_a); end
                if (valid_a !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", valid_a); end
                if (fe_a !== 1'b0) begin bad++; $display("FAIL mid_rst_fe got=%b exp=0", fe_a); end
                if (ov_a !== 1'b0) begin bad++; $display("FAIL mid_rst_ov got=%b exp=0", ov_a); end
            end
        join
        m_valid = 1'b0;
        m_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send(0, 8'h5A, 1);
        m_frame(8'h5A, 1, 0);
        repeat (8) @(negedge clk);
        total += 4;
        if (data_a !== m_data) begin bad++; $display("FAIL mid_rx_data got=%h exp=%h", data_a, m_data); end
        if (valid_a !== m_valid) begin bad++; $display("FAIL mid_rx_valid got=%b exp=%b", valid_a, m_valid); end
        if (fe_cyc !== m_fe) begin bad++; $display("FAIL mid_fe got=%0d exp=%0d", fe_cyc, m_fe); end
        if (ov_cyc !== m_ov) begin bad++; $display("FAIL mid_ov got=%0d exp=%0d", ov_cyc, m_ov); end
        ack_pulse();
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit stop;
        for (int i = 0; i < 12; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) ack_pulse();
            send(0, b, stop);
            m_frame(b, stop, 0);
            rx_a = 1'b1;
            repeat (12) @(negedge clk);
            total += 4;
            if (data_a !== m_data) begin bad++; $display("FAIL rand%0d_data got=%h exp=%h", i, data_a, m_data); end
            if (valid_a !== m_valid) begin bad++; $display("FAIL rand%0d_valid got=%b exp=%b", i, valid_a, m_valid); end
            if (fe_cyc !== m_fe) begin bad++; $display("FAIL rand%0d_fe got=%0d exp=%0d", i, fe_cyc, m_fe); end
            if (ov_cyc !== m_ov) begin bad++; $display("FAIL rand%0d_ov got=%0d exp=%0d", i, ov_cyc, m_ov); end
        end
        ack_pulse();
    endtask

    task automatic test_back_to_back();
        logic [7:0] sent[$];
        logic [7:0] got[$];
        logic [7:0] b;
        int fe_n = 0, ov_n = 0, n;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    b = 8'($urandom);
                    sent.push_back(b);
                    send(1, b, 1);
                end
            end
            begin
                repeat (256 * 160 + 200) begin
                    @(negedge clk);
                    if (valid_b) got.push_back(data_b);
                    fe_n += fe_b ? 1 : 0;
                    ov_n += ov_b ? 1 : 0;
                    ack_b = valid_b;
                end
            end
        join
        total += 3;
        if (got.size() !== 256) begin bad++; $display("FAIL b2b_count got=%0d exp=256", got.size()); end
        if (fe_n !== 0) begin bad++; $display("FAIL b2b_fe got=%0d exp=0", fe_n); end
        if (ov_n !== 0) begin bad++; $display("FAIL b2b_ov got=%0d exp=0", ov_n); end
        n = (got.size() < 256) ? got.size() : 256;
        for (int i = 0; i < n; i++) begin
            total++;
            if (got[i] !== sent[i]) begin bad++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got[i], sent[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_false_start();
        test_break();
        test_overrun();
        test_reset_midframe();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
